final_bits_flusher: RTL and testbench
=====================================

Name: final_bits_flusher

Overview:
- Output stage directly downstream of final_bits_generator.
- In normal operation it forwards the encoder's 16-bit bitstream words. It always holds back the newest word so a later carry can still be added to it.
- At end-of-frame flush it emits the held word with the final carry applied, then out_bit_1, then out_bit_2 when flag==2'b11.
- It drives a registered valid/ready output port with a last marker.

Parameters:
- OUTPUT_BITSTREAM_WIDTH, 16, width of every bitstream word (input, held and output).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  regular bitstream word present.
- in_ready  output  1  block accepts in_word / in_flush this cycle.
- in_word  input  OUTPUT_BITSTREAM_WIDTH  regular bitstream word.
- in_carry  input  1  add 1 to the currently held word; qualified by in_valid.
- in_flush  input  1  end-of-frame request; final-bits inputs are valid in this cycle.
- in_flag  input  2  flag from final_bits_generator.
- in_bit_1  input  OUTPUT_BITSTREAM_WIDTH  first final word.
- in_bit_2  input  OUTPUT_BITSTREAM_WIDTH  second final word.
- in_final_carry  input  1  carry into the held word at flush.
- out_valid  output  1  out_data valid (registered).
- out_ready  input  1  consumer accepts out_data.
- out_data  output  OUTPUT_BITSTREAM_WIDTH  output word (registered).
- out_last  output  1  marks the final word of the frame.
- flush_done  output  1  one-cycle pulse when the flush has completed.
- carry_overflow  output  1  sticky: a carry could not be absorbed.

Behaviour:
- Reset (async):
  - state=EMPTY; held word=0.
  - out_valid, out_data, out_last, flush_done, carry_overflow = 0.
  - Captured flush registers = 0.
  - Reset mid-flush aborts the flush; out_valid drops immediately and no flush_done pulse is produced.
- Output register rule: free = !out_valid || out_ready. On free with no new load, out_valid<=0 and out_last<=0.
- States: EMPTY, HELD, FL_PEND, FL_B1, FL_B2, DONE.
- in_ready:
  - EMPTY: 1.
  - HELD: equal to free.
  - All flush states and DONE: 0.
- EMPTY:
  - in_valid & in_ready: held<=in_word; go to HELD.
  - in_carry with no held word: ignored, carry_overflow<=1.
- HELD, in_valid & in_ready:
  - out_data<=held + in_carry (modulo 2^W), out_valid<=1, out_last<=0; held<=in_word.
  - held==all-ones with in_carry=1: emit 0 and set carry_overflow. No further propagation.
- Flush acceptance:
  - in_flush is accepted when in_ready=1 and in_valid=0.
  - Accepting captures in_flag, in_bit_1, in_bit_2 and in_final_carry.
  - Next state is FL_PEND from HELD, FL_B1 from EMPTY.
  - From EMPTY, in_final_carry=1 sets carry_overflow.
- in_valid & in_flush in the same cycle:
  - The word is accepted first.
  - The flush is latched into an internal flush_req together with captured copies of its inputs.
  - flush_req is acted on in the next cycle in which in_ready=1; no further words are accepted meanwhile.
- FL_PEND: on free, emit held + final_carry (same wrap/overflow rule as above), out_last=0; go to FL_B1.
- FL_B1: on free, emit bit_1.
  - If captured flag==2'b11: out_last=0; go to FL_B2.
  - Otherwise (01, 00 and 10 all treated as 01): out_last=1; go to DONE.
- FL_B2: on free, emit bit_2 with out_last=1; go to DONE.
- DONE: when the last word handshakes (out_valid & out_ready), pulse flush_done for one cycle, clear held and flush_req, go to EMPTY.
- carry_overflow is cleared only by reset.
- Latency: an accepted word appears on out_data one cycle after the next word (or a flush) pushes it out. Each flush word takes at least 1 cycle; out_ready stalls hold the state.

Test Plan:
- Words 0x1111, 0x2222, 0x3333 with out_ready=1 -> out_data shows 0x1111 then 0x2222; 0x3333 stays held, no out_last.
- Held 0x00FF, then in_word 0x0500 with in_carry=1 -> output 0x0100; held=0x0500. Held 0xFFFF with carry -> output 0x0000, carry_overflow=1.
- Held 0xABCD; flush with flag=01, bit_1=0x8000, final_carry=1 -> outputs 0xABCE, 0x8000 (last=1); flush_done pulses one cycle after the last handshake.
- EMPTY; flush with flag=11, bit_1=0x1234, bit_2=0x5600 -> outputs 0x1234, 0x5600 (last only on 0x5600); in_ready=0 throughout the flush.
- out_ready held low for 5 cycles during FL_B1 -> out_data stays stable at bit_1; no word is lost or duplicated.
- in_valid=1 (0x0F0F) with in_flush=1 in the same cycle -> the word is accepted, then the flush runs: previous held word, 0x0F0F, then bit_1.
- Reset asserted in FL_B2 -> out_valid goes 0 immediately; state returns to EMPTY; no flush_done.

Source files
------------

// File: rtl/final_bits_flusher.sv
// Output stage after final_bits_generator: holds back the newest bitstream word so a
// later carry can still land in it, then drains held word and final bits on flush.
module final_bits_flusher #(
    parameter int OUTPUT_BITSTREAM_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_word,
    input  logic                              in_carry,
    input  logic                              in_flush,
    input  logic [1:0]                        in_flag,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [OUTPUT_BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic                              in_final_carry,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_data,
    output logic                              out_last,
    output logic                              flush_done,
    output logic                              carry_overflow
);
    localparam int W = OUTPUT_BITSTREAM_WIDTH;

    typedef enum logic [2:0] {EMPTY, HELD, FL_PEND, FL_B1, FL_B2, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   held_q, held_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           flush_done_q, flush_done_d;
    logic           carry_overflow_q, carry_overflow_d;
    logic [1:0]     flag_q, flag_d;
    logic [W-1:0]   bit_1_q, bit_1_d;
    logic [W-1:0]   bit_2_q, bit_2_d;
    logic           final_carry_q, final_carry_d;
    logic           flush_req_q, flush_req_d;

    logic           free;
    logic           ready_int;
    logic           word_acc;
    logic           flush_acc;
    logic           flush_go;
    logic [W:0]     word_sum;
    logic [W:0]     final_sum;

    assign free      = !out_valid_q || out_ready;
    assign word_sum  = {1'b0, held_q} + {{W{1'b0}}, in_carry};
    assign final_sum = {1'b0, held_q} + {{W{1'b0}}, final_carry_q};

    always_comb begin
        case (state_q)
            EMPTY:   ready_int = 1'b1;
            HELD:    ready_int = free;
            default: ready_int = 1'b0;
        endcase
    end

    // A latched flush request blocks new words but is serviced on the internal ready.
    assign in_ready  = ready_int && !flush_req_q;
    assign word_acc  = in_valid && in_ready;
    assign flush_acc = in_flush && in_ready && !in_valid;
    assign flush_go  = flush_req_q && ready_int;

    always_comb begin
        state_d          = state_q;
        held_d           = held_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_last_d       = out_last_q;
        flush_done_d     = 1'b0;
        carry_overflow_d = carry_overflow_q;
        flag_d           = flag_q;
        bit_1_d          = bit_1_q;
        bit_2_d          = bit_2_q;
        final_carry_d    = final_carry_q;
        flush_req_d      = flush_req_q;

        if (free) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if ((word_acc && in_flush) || flush_acc) begin
            flag_d        = in_flag;
            bit_1_d       = in_bit_1;
            bit_2_d       = in_bit_2;
            final_carry_d = in_final_carry;
        end

        case (state_q)
            EMPTY: begin
                if (word_acc) begin
                    held_d  = in_word;
                    state_d = HELD;
                    if (in_carry) carry_overflow_d = 1'b1;
                    if (in_flush) flush_req_d = 1'b1;
                end else if (flush_acc) begin
                    state_d = FL_B1;
                    if (in_final_carry) carry_overflow_d = 1'b1;
                end else if (flush_go) begin
                    state_d     = FL_B1;
                    flush_req_d = 1'b0;
                    if (final_carry_q) carry_overflow_d = 1'b1;
                end
            end
            HELD: begin
                if (flush_go) begin
                    state_d     = FL_PEND;
                    flush_req_d = 1'b0;
                end else if (word_acc) begin
                    out_data_d  = word_sum[W-1:0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    held_d      = in_word;
                    if (word_sum[W]) carry_overflow_d = 1'b1;
                    if (in_flush) flush_req_d = 1'b1;
                end else if (flush_acc) begin
                    state_d = FL_PEND;
                end
            end
            FL_PEND: begin
                if (free) begin
                    out_data_d  = final_sum[W-1:0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    if (final_sum[W]) carry_overflow_d = 1'b1;
                    state_d = FL_B1;
                end
            end
            FL_B1: begin
                if (free) begin
                    out_data_d  = bit_1_q;
                    out_valid_d = 1'b1;
                    if (flag_q == 2'b11) begin
                        out_last_d = 1'b0;
                        state_d    = FL_B2;
                    end else begin
                        out_last_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            FL_B2: begin
                if (free) begin
                    out_data_d  = bit_2_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    flush_done_d = 1'b1;
                    held_d       = '0;
                    flush_req_d  = 1'b0;
                    state_d      = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= EMPTY;
            held_q           <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_last_q       <= 1'b0;
            flush_done_q     <= 1'b0;
            carry_overflow_q <= 1'b0;
            flag_q           <= '0;
            bit_1_q          <= '0;
            bit_2_q          <= '0;
            final_carry_q    <= 1'b0;
            flush_req_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            held_q           <= held_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_last_q       <= out_last_d;
            flush_done_q     <= flush_done_d;
            carry_overflow_q <= carry_overflow_d;
            flag_q           <= flag_d;
            bit_1_q          <= bit_1_d;
            bit_2_q          <= bit_2_d;
            final_carry_q    <= final_carry_d;
            flush_req_q      <= flush_req_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign flush_done     = flush_done_q;
    assign carry_overflow = carry_overflow_q;
endmodule

// File: tb/tb_final_bits_flusher.sv
// Directed bench for final_bits_flusher: streaming, carry wrap, flush variants,
// output stalls, word+flush collision and reset during flush.
module tb_final_bits_flusher;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        in_carry;
    logic        in_flush;
    logic [1:0]  in_flag;
    logic [15:0] in_bit_1;
    logic [15:0] in_bit_2;
    logic        in_final_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        flush_done;
    logic        carry_overflow;

    int n_checks;
    int n_fail;

    final_bits_flusher #(.OUTPUT_BITSTREAM_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .in_carry(in_carry), .in_flush(in_flush), .in_flag(in_flag),
        .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_final_carry(in_final_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .flush_done(flush_done), .carry_overflow(carry_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_word = '0; in_carry = 0; in_flush = 0; in_flag = '0;
        in_bit_1 = '0; in_bit_2 = '0; in_final_carry = 0; out_ready = 1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h exp 0000", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b exp 0", out_last); end
        n_checks++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b exp 0", flush_done); end
        n_checks++; if (carry_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b exp 0", carry_overflow); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", in_ready); end
        step();
        reset = 0;
    endtask

    task automatic test_stream();
        apply_reset();
        in_valid = 1; in_word = 16'h1111; step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_held: valid %b exp 0", out_valid); end
        in_word = 16'h2222; step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_last !== 1'b0) begin n_fail++; $display("FAIL stream_w0: v%b d%h l%b exp v1 d1111 l0", out_valid, out_data, out_last); end
        in_word = 16'h3333; step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h2222 || out_last !== 1'b0) begin n_fail++; $display("FAIL stream_w1: v%b d%h l%b exp v1 d2222 l0", out_valid, out_data, out_last); end
        in_valid = 0; step();
        n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL stream_hold3333: v%b l%b exp v0 l0", out_valid, out_last); end
        in_flush = 1; in_flag = 2'b01; in_bit_1 = 16'hBEEF; step();
        in_flush = 0; step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_last !== 1'b0) begin n_fail++; $display("FAIL stream_drain_held: v%b d%h l%b exp v1 d3333 l0", out_valid, out_data, out_last); end
        step();
        n_checks++; if (out_data !== 16'hBEEF || out_last !== 1'b1) begin n_fail++; $display("FAIL stream_drain_b1: d%h l%b exp dBEEF l1", out_data, out_last); end
        step();
        n_checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_done: done%b v%b exp done1 v0", flush_done, out_valid); end
    endtask

    task automatic test_carry();
        apply_reset();
        in_valid = 1; in_word = 16'h00FF; step();
        in_word = 16'h0500; in_carry = 1; step();
        n_checks++; if (out_data !== 16'h0100 || carry_overflow !== 1'b0) begin n_fail++; $display("FAIL carry_add: d%h ovf%b exp d0100 ovf0", out_data, carry_overflow); end
        in_word = 16'hFFFF; in_carry = 0; step();
        n_checks++; if (out_data !== 16'h0500) begin n_fail++; $display("FAIL carry_held: d%h exp 0500", out_data); end
        in_word = 16'h0001; in_carry = 1; step();
        n_checks++; if (out_data !== 16'h0000 || carry_overflow !== 1'b1) begin n_fail++; $display("FAIL carry_wrap: d%h ovf%b exp d0000 ovf1", out_data, carry_overflow); end
        in_valid = 0; in_carry = 0; step(); step();
        n_checks++; if (carry_overflow !== 1'b1) begin n_fail++; $display("FAIL carry_sticky: ovf%b exp 1", carry_overflow); end
        apply_reset();
        in_valid = 1; in_word = 16'h0042; in_carry = 1; step();
        n_checks++; if (carry_overflow !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL carry_empty: ovf%b v%b exp ovf1 v0", carry_overflow, out_valid); end
        in_valid = 0; in_carry = 0;
    endtask

    task automatic test_flush_flag01();
        apply_reset();
        in_valid = 1; in_word = 16'hABCD; step();
        in_valid = 0; in_flush = 1; in_flag = 2'b01; in_bit_1 = 16'h8000; in_bit_2 = 16'hFFFF; in_final_carry = 1; step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL f01_ready: got %b exp 0", in_ready); end
        in_flush = 0; in_final_carry = 0; step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hABCE || out_last !== 1'b0) begin n_fail++; $display("FAIL f01_held: v%b d%h l%b exp v1 dABCE l0", out_valid, out_data, out_last); end
        step();
        n_checks++; if (out_data !== 16'h8000 || out_last !== 1'b1 || flush_done !== 1'b0) begin n_fail++; $display("FAIL f01_b1: d%h l%b done%b exp d8000 l1 done0", out_data, out_last, flush_done); end
        step();
        n_checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0 || carry_overflow !== 1'b0) begin n_fail++; $display("FAIL f01_done: done%b v%b ovf%b exp 1 0 0", flush_done, out_valid, carry_overflow); end
        step();
        n_checks++; if (flush_done !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL f01_after: done%b rdy%b exp done0 rdy1", flush_done, in_ready); end
    endtask

    task automatic test_flush_flag11();
        apply_reset();
        in_flush = 1; in_flag = 2'b11; in_bit_1 = 16'h1234; in_bit_2 = 16'h5600; in_final_carry = 0; step();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL f11_accept: rdy%b v%b exp rdy0 v0", in_ready, out_valid); end
        in_flush = 0; step();
        n_checks++; if (out_data !== 16'h1234 || out_last !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL f11_b1: d%h l%b rdy%b exp d1234 l0 rdy0", out_data, out_last, in_ready); end
        step();
        n_checks++; if (out_data !== 16'h5600 || out_last !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL f11_b2: d%h l%b rdy%b exp d5600 l1 rdy0", out_data, out_last, in_ready); end
        step();
        n_checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL f11_done: done%b v%b exp done1 v0", flush_done, out_valid); end
    endtask

    task automatic test_stall();
        apply_reset();
        in_valid = 1; in_word = 16'h1111; step();
        in_valid = 0; in_flush = 1; in_flag = 2'b10; in_bit_1 = 16'hC0DE; step();
        in_flush = 0; step();
        n_checks++; if (out_data !== 16'h1111 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_held: d%h v%b exp d1111 v1", out_data, out_valid); end
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (out_data !== 16'h1111 || out_valid !== 1'b1 || out_last !== 1'b0) begin n_fail++; $display("FAIL stall_pend%0d: d%h v%b l%b exp d1111 v1 l0", i, out_data, out_valid, out_last); end
        end
        out_ready = 1; step();
        n_checks++; if (out_data !== 16'hC0DE || out_last !== 1'b1) begin n_fail++; $display("FAIL stall_b1: d%h l%b exp dC0DE l1", out_data, out_last); end
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if (out_data !== 16'hC0DE || out_valid !== 1'b1 || flush_done !== 1'b0) begin n_fail++; $display("FAIL stall_b1_hold%0d: d%h v%b done%b exp dC0DE v1 done0", i, out_data, out_valid, flush_done); end
        end
        out_ready = 1; step();
        n_checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done: done%b v%b exp done1 v0", flush_done, out_valid); end
    endtask

    task automatic test_word_and_flush();
        apply_reset();
        in_valid = 1; in_word = 16'hAAAA; step();
        in_word = 16'h0F0F; in_flush = 1; in_flag = 2'b01; in_bit_1 = 16'h7777; in_final_carry = 0; step();
        n_checks++; if (out_data !== 16'hAAAA || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL wf_prev: d%h v%b rdy%b exp dAAAA v1 rdy0", out_data, out_valid, in_ready); end
        in_word = 16'hDEAD; in_flush = 0; step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL wf_pend: v%b rdy%b exp v0 rdy0", out_valid, in_ready); end
        in_valid = 0; step();
        n_checks++; if (out_data !== 16'h0F0F || out_valid !== 1'b1 || out_last !== 1'b0) begin n_fail++; $display("FAIL wf_word: d%h v%b l%b exp d0F0F v1 l0", out_data, out_valid, out_last); end
        step();
        n_checks++; if (out_data !== 16'h7777 || out_last !== 1'b1) begin n_fail++; $display("FAIL wf_b1: d%h l%b exp d7777 l1", out_data, out_last); end
        step();
        n_checks++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL wf_done: done%b v%b exp done1 v0", flush_done, out_valid); end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        in_flush = 1; in_flag = 2'b11; in_bit_1 = 16'h1111; in_bit_2 = 16'h2222; step();
        in_flush = 0; step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1111) begin n_fail++; $display("FAIL rmf_b1: v%b d%h exp v1 d1111", out_valid, out_data); end
        out_ready = 0;
        #2 reset = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_async: v%b d%h rdy%b exp v0 d0000 rdy1", out_valid, out_data, in_ready); end
        step();
        reset = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (flush_done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmf_idle%0d: done%b v%b rdy%b exp 0 0 1", i, flush_done, out_valid, in_ready); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_carry();
        test_flush_flag01();
        test_flush_flag11();
        test_stall();
        test_word_and_flush();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
